// File: rtl/ps2_transmitter.sv
// Host-to-device PS/2 transmitter: request-to-send, 8N-odd frame, device ACK.
// Optional macro PS2_TX_TIMEOUT_EN adds an abort when the device stops clocking.
module ps2_transmitter #(
   parameter int unsigned INHIBIT_CYCLES = 1200,
   parameter int unsigned FILTER_LEN     = 20
`ifdef PS2_TX_TIMEOUT_EN
   ,parameter int unsigned TIMEOUT_CYCLES = 200000
`endif
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic       kclk_in,
   input  logic       kdata_in,
   output logic       kclk_oe,
   output logic       kdata_oe,
   output logic       busy,
   output logic       done,
   output logic       ack_err,
   output logic       timeout
);
   localparam int unsigned INH_W = (INHIBIT_CYCLES > 2) ? $clog2(INHIBIT_CYCLES) : 2;
   localparam int unsigned FLT_W = $clog2(FILTER_LEN + 1);
   localparam int unsigned BIT_W = 4;
   localparam int unsigned FRM_W = 10;

   typedef enum logic [2:0] {
      S_IDLE, S_INHIBIT, S_RELEASE, S_SEND, S_ACK, S_WAIT_IDLE
   } state_t;

   state_t             r_state, state_nxt;
   logic [INH_W-1:0]   r_inh_cnt, inh_nxt;
   logic [BIT_W-1:0]   r_bit_cnt, bit_nxt;
   logic [FRM_W-1:0]   r_frame, frame_nxt;
   logic               r_kclk_oe, kclk_oe_nxt;
   logic               r_kdata_oe, kdata_oe_nxt;
   logic               r_ack_bit, ack_bit_nxt;
   logic               r_ack_err, ack_err_nxt;
   logic               r_done, done_nxt;
   logic               r_timeout, timeout_nxt;
   logic               r_tx_ready, r_busy;

   // index 0 = kclk, index 1 = kdata
   logic [1:0]         r_sync1, r_sync2, r_filt;
   logic [FLT_W-1:0]   r_fcnt [2];
   logic               r_kclk_d;
   logic               w_fall;
   logic               w_to_hit;

   // Synchronize, then only accept a new level after FILTER_LEN identical samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1  <= 2'b11;
         r_sync2  <= 2'b11;
         r_filt   <= 2'b11;
         r_kclk_d <= 1'b1;
         for (int i = 0; i < 2; i++) r_fcnt[i] <= '0;
      end else begin
         r_sync1  <= {kdata_in, kclk_in};
         r_sync2  <= r_sync1;
         r_kclk_d <= r_filt[0];
         for (int i = 0; i < 2; i++) begin
            if (r_sync2[i] == r_filt[i]) begin
               r_fcnt[i] <= '0;
            end else if (r_fcnt[i] == FLT_W'(FILTER_LEN - 1)) begin
               r_filt[i] <= r_sync2[i];
               r_fcnt[i] <= '0;
            end else begin
               r_fcnt[i] <= r_fcnt[i] + FLT_W'(1);
            end
         end
      end
   end

   assign w_fall = r_kclk_d & ~r_filt[0];

`ifdef PS2_TX_TIMEOUT_EN
   localparam int unsigned TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 2;
   logic [TO_W-1:0] r_to_cnt;
   logic            w_to_run;

   assign w_to_run = (r_state == S_RELEASE) || (r_state == S_SEND) || (r_state == S_ACK);
   assign w_to_hit = w_to_run && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        r_to_cnt <= '0;
      else if (w_to_run) r_to_cnt <= r_to_cnt + TO_W'(1);
      else               r_to_cnt <= '0;
   end
`else
   assign w_to_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_inh_cnt  <= '0;
         r_bit_cnt  <= '0;
         r_frame    <= '0;
         r_kclk_oe  <= 1'b0;
         r_kdata_oe <= 1'b0;
         r_ack_bit  <= 1'b0;
         r_ack_err  <= 1'b0;
         r_done     <= 1'b0;
         r_timeout  <= 1'b0;
         r_tx_ready <= 1'b1;
         r_busy     <= 1'b0;
      end else begin
         r_state    <= state_nxt;
         r_inh_cnt  <= inh_nxt;
         r_bit_cnt  <= bit_nxt;
         r_frame    <= frame_nxt;
         r_kclk_oe  <= kclk_oe_nxt;
         r_kdata_oe <= kdata_oe_nxt;
         r_ack_bit  <= ack_bit_nxt;
         r_ack_err  <= ack_err_nxt;
         r_done     <= done_nxt;
         r_timeout  <= timeout_nxt;
         r_tx_ready <= (state_nxt == S_IDLE);
         r_busy     <= (state_nxt != S_IDLE);
      end
   end

   always_comb begin
      state_nxt    = r_state;
      inh_nxt      = r_inh_cnt;
      bit_nxt      = r_bit_cnt;
      frame_nxt    = r_frame;
      kclk_oe_nxt  = r_kclk_oe;
      kdata_oe_nxt = r_kdata_oe;
      ack_bit_nxt  = r_ack_bit;
      ack_err_nxt  = r_ack_err;
      done_nxt     = 1'b0;
      timeout_nxt  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (tx_valid) begin
               frame_nxt    = {1'b1, ~^tx_data, tx_data};
               bit_nxt      = '0;
               inh_nxt      = '0;
               kclk_oe_nxt  = 1'b1;
               kdata_oe_nxt = 1'b0;
               state_nxt    = S_INHIBIT;
            end
         end
         S_INHIBIT: begin
            inh_nxt = r_inh_cnt + INH_W'(1);
            // start bit goes low one cycle before the clock is released
            if (r_inh_cnt == INH_W'(INHIBIT_CYCLES - 2)) kdata_oe_nxt = 1'b1;
            if (r_inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
               kclk_oe_nxt = 1'b0;
               state_nxt   = S_RELEASE;
            end
         end
         S_RELEASE: begin
            if (r_filt[0]) state_nxt = S_SEND;
         end
         S_SEND: begin
            if (w_fall) begin
               kdata_oe_nxt = ~r_frame[0];
               frame_nxt    = {1'b0, r_frame[FRM_W-1:1]};
               bit_nxt      = r_bit_cnt + BIT_W'(1);
               if (r_bit_cnt == BIT_W'(9)) state_nxt = S_ACK;
            end
         end
         S_ACK: begin
            if (w_fall) begin
               ack_bit_nxt = r_filt[1];
               state_nxt   = S_WAIT_IDLE;
            end
         end
         S_WAIT_IDLE: begin
            if (r_filt == 2'b11) begin
               done_nxt    = 1'b1;
               ack_err_nxt = r_ack_bit;
               state_nxt   = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
      if (w_to_hit) begin
         kclk_oe_nxt  = 1'b0;
         kdata_oe_nxt = 1'b0;
         timeout_nxt  = 1'b1;
         state_nxt    = S_IDLE;
      end
   end

   assign tx_ready = r_tx_ready;
   assign busy     = r_busy;
   assign kclk_oe  = r_kclk_oe;
   assign kdata_oe = r_kdata_oe;
   assign done     = r_done;
   assign ack_err  = r_ack_err;
   assign timeout  = r_timeout;

endmodule

// File: tb/tb_ps2_transmitter.sv
// Bench for ps2_transmitter: open-drain bus with a PS/2 device model and a done-driven scoreboard.
`timescale 1ns/1ps
module tb_ps2_transmitter;
   localparam int INH  = 1200;
   localparam int TO   = 5000;
   localparam int HALF = 50;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready, kclk_oe, kdata_oe, busy, done, ack_err, timeout;
   logic       dev_clk_low = 1'b0;
   logic       dev_data_low = 1'b0;
   logic       kclk_line, kdata_line;

   assign kclk_line  = ~(kclk_oe | dev_clk_low);
   assign kdata_line = ~(kdata_oe | dev_data_low);

   always #5 clk = ~clk;

   ps2_transmitter #(
      .INHIBIT_CYCLES(INH),
      .FILTER_LEN(20)
`ifdef PS2_TX_TIMEOUT_EN
      ,.TIMEOUT_CYCLES(TO)
`endif
   ) dut (
      .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .kclk_in(kclk_line), .kdata_in(kdata_line),
      .kclk_oe(kclk_oe), .kdata_oe(kdata_oe), .busy(busy), .done(done),
      .ack_err(ack_err), .timeout(timeout)
   );

   typedef struct { logic [7:0] data; logic par; logic ack_err; } exp_t;
   typedef struct { logic [7:0] data; logic par; logic stop; } rx_t;
   exp_t exp_q[$];
   rx_t  rx_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   n_done = 0;
   int   exp_done = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Odd parity: the parity bit makes the total count of ones odd.
   function automatic logic odd_par(input logic [7:0] d);
      int ones = 0;
      for (int i = 0; i < 8; i++) ones += int'((d >> i) & 8'h01);
      return (ones % 2 == 0) ? 1'b1 : 1'b0;
   endfunction

   always @(negedge clk) begin : monitor
      exp_t e;
      rx_t  r;
      if (rst_n === 1'b1 && done === 1'b1) begin
         n_done++;
         if (exp_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("ack_err", ack_err, e.ack_err);
            check("tx_ready_at_done", tx_ready, 1);
            if (rx_q.size() == 0) begin
               check("rx_frame_present", 32'd0, 32'd1);
            end else begin
               r = rx_q.pop_front();
               check("rx_data", r.data, e.data);
               check("rx_parity", r.par, e.par);
               check("rx_stop", r.stop, 1);
            end
         end
      end
   end

   task automatic send(input logic [7:0] d, input bit ack);
      int   w;
      exp_t e;
      w = 0;
      while (tx_ready !== 1'b1 && w < 20000) begin w++; @(negedge clk); end
      check("ready_before_send", tx_ready, 1);
      tx_data  = d;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      e.data = d;
      e.par = odd_par(d);
      e.ack_err = !ack;
      exp_q.push_back(e);
      check("busy_after_accept", {busy, tx_ready}, 2'b10);
   endtask

   // Device side: measure request-to-send, clock 11 pulses, sample on rising edges.
   task automatic device(input logic [7:0] d, input bit do_ack, input bit glitch, input int abort_fall);
      int         cnt;
      rx_t        r;
      logic [9:0] bits;
      bits = '0;
      cnt = 0;
      while (kclk_oe === 1'b1 && cnt < 5000) begin cnt++; @(negedge clk); end
      check("inhibit_len", cnt, INH);
      check("start_bit_low", kdata_line, 0);
      tx_data = ~d;
      tx_valid = 1'b1;
      repeat (3) @(negedge clk);
      tx_valid = 1'b0;
      repeat (57) @(negedge clk);
      for (int k = 1; k <= 11; k++) begin
         dev_clk_low = 1'b1;
         if (k == abort_fall) begin
            repeat (30) @(negedge clk);
            rst_n = 1'b0;
            #1;
            check("reset_kclk_oe", kclk_oe, 0);
            check("reset_kdata_oe", kdata_oe, 0);
            check("reset_busy", busy, 0);
            dev_clk_low = 1'b0;
            repeat (5) @(negedge clk);
            rst_n = 1'b1;
            return;
         end
         repeat (HALF) @(negedge clk);
         if (k <= 10) bits[k-1] = kdata_line;
         dev_clk_low = 1'b0;
         if (glitch && k == 5) begin
            repeat (30) @(negedge clk);
            dev_clk_low = 1'b1;
            repeat (5) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (HALF - 35) @(negedge clk);
         end else if (k == 10) begin
            repeat (10) @(negedge clk);
            dev_data_low = do_ack;
            repeat (HALF - 10) @(negedge clk);
         end else if (k == 11) begin
            repeat (10) @(negedge clk);
            dev_data_low = 1'b0;
         end else begin
            repeat (HALF) @(negedge clk);
         end
      end
      r.data = bits[7:0];
      r.par  = bits[8];
      r.stop = bits[9];
      rx_q.push_back(r);
   endtask

   task automatic run_frame(input logic [7:0] d, input bit ack, input bit glitch, input int abort_fall);
      int w;
      send(d, ack);
      device(d, ack, glitch, abort_fall);
      if (abort_fall > 0) void'(exp_q.pop_back());
      else exp_done++;
      w = 0;
      while (tx_ready !== 1'b1 && w < 3000) begin w++; @(negedge clk); end
      check("frame_end_ready", tx_ready, 1);
      repeat (5) @(negedge clk);
   endtask

   initial begin : watchdog
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      n_bad++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic [7:0] d;
      bit         a, g;
      int         w, c;
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("reset_outputs", {tx_ready, busy, kclk_oe, kdata_oe, done, ack_err, timeout}, 7'b1000000);

      run_frame(8'hED, 1'b1, 1'b0, 0);
      run_frame(8'hF4, 1'b1, 1'b0, 0);
      run_frame(8'h00, 1'b1, 1'b0, 0);
      run_frame(8'hFF, 1'b1, 1'b0, 0);
      run_frame(8'hED, 1'b0, 1'b0, 0);
      check("ready_after_nack", tx_ready, 1);
      run_frame(8'hED, 1'b1, 1'b1, 0);
      run_frame(8'hA3, 1'b1, 1'b0, 4);
      check("no_done_after_abort", n_done, exp_done);
      run_frame(8'h55, 1'b1, 1'b0, 0);
      for (int i = 0; i < 5; i++) begin
         d = 8'($urandom_range(0, 255));
         a = ($urandom_range(0, 1) == 1);
         g = ($urandom_range(0, 2) == 0);
         run_frame(d, a, g, 0);
      end

`ifdef PS2_TX_TIMEOUT_EN
      send(8'h3C, 1'b1);
      void'(exp_q.pop_back());
      w = 0;
      while (kclk_oe === 1'b1 && w < 5000) begin w++; @(negedge clk); end
      c = 0;
      while (timeout !== 1'b1 && c < 20000) begin c++; @(negedge clk); end
      check("timeout_cycles", c, TO);
      check("timeout_lines_released", {kclk_oe, kdata_oe, done}, 3'b000);
      @(negedge clk);
      check("timeout_one_pulse", {timeout, tx_ready}, 2'b01);
      repeat (50) @(negedge clk);
`endif

      repeat (100) @(negedge clk);
      check("done_count", n_done, exp_done);
      check("scoreboard_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
